hex_display_arbiter: RTL and testbench
======================================

# hex_display_arbiter

Shares the six-digit HEX display between up to NUM_SRC producers on the DE1-SoC, such as Nios status, DCT engine progress and debug counters. Each producer pushes a 24-bit, six-nibble snapshot whenever it likes. The block keeps the latest snapshot per source and rotates the display round-robin, advancing on a dwell timer or on a debounced KEY press. Its outputs feed the existing per-digit hex decoders in the board top level.

## Interface
- NUM_SRC, 4: number of requesting sources, 2..8.
- DWELL_CYCLES, 50_000_000: clk cycles each source is shown before auto-advance (1 s at 50 MHz).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples needed to accept a key level change (20 ms).
- clk  in  1  system clock, CLOCK_50 domain.
- reset  in  1  synchronous, active-high.
- src_valid  in  NUM_SRC  bit i high means src_data slice i is a new snapshot this cycle.
- src_data  in  24*NUM_SRC  slice i is bits [24i+23:24i]; nibble k of a slice drives HEXk.
- src_ack  out  NUM_SRC  registered copy of src_valid, one cycle late.
- key_next_n  in  1  raw active-low pushbutton (KEY[n]), asynchronous to clk.
- hold  in  1  level (SW); when high, timer advance is frozen.
- hex_digits  out  24  nibble k goes to hex decoder k.
- digit_blank  out  6  bit k high means HEXk is forced off (all segments 1).
- cur_src  out  $clog2(NUM_SRC)  index of the source currently displayed.

## Operation
- Snapshot bank: per source, a 24-bit register snap[i] and a flag has_data[i].
  - src_valid[i] high: snap[i] <= slice i, has_data[i] <= 1.
  - Sources are written independently; all may write in the same cycle.
  - A snapshot is never rejected. Producers may hold valid high continuously, and the last value wins.
- Key path:
  - Two-flop synchronizer, then debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it. The counter clears on any matching sample.
  - A press event is a one-cycle pulse when the debounced level goes 1 to 0. Release produces no event.
- Dwell counter:
  - Counts 0..DWELL_CYCLES-1 while hold=0. Expiry is counter==DWELL_CYCLES-1.
  - hold=1 forces the counter to 0.
  - Any advance, whether from the timer or the key, resets it to 0.
- Advance (timer expiry OR press event, merged into one advance):
  - cur_src <= first j in order cur+1, cur+2, …, cur+NUM_SRC-1 (mod NUM_SRC) with has_data[j]=1.
  - If no such j exists, cur_src is unchanged.
  - The key still advances while hold=1.
- Display:
  - hex_digits <= snap[cur_src] each cycle.
  - digit_blank <= has_data[cur_src] ? 6'h00 : 6'h3F.
  - Both use the post-update cur_src.
- Reset:
  - cur_src=0, snap all 0, has_data all 0.
  - hex_digits=0, digit_blank=6'h3F, src_ack=0.
  - Dwell and debounce counters 0; synchronizer flops and debounced level 1 (released).

## Timing
- src_valid[i] at cycle t: snap[i]/has_data[i] update at t+1. src_ack[i] is high during t+1.
  - If i==cur_src, hex_digits/digit_blank reflect the new value at t+2.
- Key: a physical press must be stable for DEBOUNCE_CYCLES after the 2-cycle synchronizer.
  - Event fires at cycle 2+DEBOUNCE_CYCLES after the first low sample, ±1.
  - cur_src changes the next cycle; display follows one cycle after that.
- Timer: with hold=0 and no key, cur_src changes every DWELL_CYCLES cycles exactly.
- Simultaneous expiry and press event: exactly one advance.
- Snapshot write to source j in the same cycle as an advance search: the search uses has_data before the write. A first-time write to j is not eligible until the next cycle.
- hold toggled 1 to 0: counting restarts from 0, so the next advance is DWELL_CYCLES cycles later.
- Reset mid-count or mid-debounce: everything returns to reset values the next edge. Partial debounce progress is discarded.
- Key bounce shorter than DEBOUNCE_CYCLES: no event.

## Test plan
Bench uses NUM_SRC=4, DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
1. Reset, then idle 20 cycles -> cur_src=0, digit_blank=6'h3F, hex_digits=0, src_ack=0, no advance because no source has data.
2. src_valid=4'b0101, src0=24'h123456, src2=24'hABCDEF for one cycle, then idle -> src_ack=4'b0101 one cycle later. hex_digits=24'h123456, digit_blank=0 two cycles after valid. cur_src goes 0→2→0 every 8 cycles, showing 24'hABCDEF while on 2.
3. Same data, hold=1 for 30 cycles, then key_next_n low for 8 cycles -> no timer advance. One advance to cur_src=2 about 6–7 cycles after key low. Holding the key low longer gives no further advance.
4. key_next_n pulses low for 3 cycles, repeated 5 times with 3-cycle gaps, hold=1 -> cur_src never changes.
5. Timer expiry and debounced press aligned on the same cycle, sources 1 and 3 valid, cur=1 -> cur_src=3 (single step), counter restarts, next timer advance back to 1 occurs 8 cycles later.
6. Continuous src_valid[0] with incrementing data; assert reset for 1 cycle mid-stream -> cycle after reset: digit_blank=6'h3F, has_data cleared. Data reappears 2 cycles after the next valid sample.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: keeps the latest snapshot per source and rotates the HEX display round-robin on dwell timer or debounced key press
module hex_display_arbiter #(
    parameter int NUM_SRC         = 4,
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [24*NUM_SRC-1:0]      src_data,
    output logic [NUM_SRC-1:0]         src_ack,
    input  logic                       key_next_n,
    input  logic                       hold,
    output logic [23:0]                hex_digits,
    output logic [5:0]                 digit_blank,
    output logic [$clog2(NUM_SRC)-1:0] cur_src
);
    localparam int SW  = $clog2(NUM_SRC);
    localparam int DW  = $clog2(DWELL_CYCLES + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [23:0]        snap [NUM_SRC];
    logic [NUM_SRC-1:0] has_data;
    logic               key_s1, key_s2, key_deb;
    logic [DBW-1:0]     deb_cnt;
    logic [DW-1:0]      dwell_cnt;
    logic               deb_done, press, expire, adv, found;
    logic [SW-1:0]      nxt, j;
    assign deb_done = key_s2 != key_deb && deb_cnt == DBW'(DEBOUNCE_CYCLES - 1);
    assign press    = deb_done && !key_s2;
    assign expire   = !hold && dwell_cnt == DW'(DWELL_CYCLES - 1);
    assign adv      = press || expire;
    // Search uses has_data before this cycle's writes, so a first-time write is not yet eligible
    always_comb begin
        nxt   = cur_src;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k < NUM_SRC; k++) begin
            j = SW'((int'(cur_src) + k) % NUM_SRC);
            if (!found && has_data[j]) begin
                nxt   = j;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1      <= 1'b1;
            key_s2      <= 1'b1;
            key_deb     <= 1'b1;
            deb_cnt     <= '0;
            dwell_cnt   <= '0;
            cur_src     <= '0;
            has_data    <= '0;
            src_ack     <= '0;
            hex_digits  <= '0;
            digit_blank <= 6'h3F;
            for (int i = 0; i < NUM_SRC; i++) snap[i] <= '0;
        end else begin
            key_s1      <= key_next_n;
            key_s2      <= key_s1;
            deb_cnt     <= (key_s2 == key_deb || deb_done) ? '0 : deb_cnt + 1'b1;
            key_deb     <= deb_done ? key_s2 : key_deb;
            dwell_cnt   <= (hold || adv) ? '0 : dwell_cnt + 1'b1;
            cur_src     <= adv ? nxt : cur_src;
            src_ack     <= src_valid;
            has_data    <= has_data | src_valid;
            for (int i = 0; i < NUM_SRC; i++)
                if (src_valid[i]) snap[i] <= src_data[24*i +: 24];
            hex_digits  <= snap[cur_src];
            digit_blank <= has_data[cur_src] ? 6'h00 : 6'h3F;
        end
    end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: table-driven and directed checks of the HEX display arbiter with short dwell/debounce
module tb_hex_display_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_valid;
    logic [95:0] src_data;
    logic [3:0]  src_ack;
    logic        key_next_n;
    logic        hold;
    logic [23:0] hex_digits;
    logic [5:0]  digit_blank;
    logic [1:0]  cur_src;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         n;
        logic       rst;
        logic [3:0] v;
        logic       hold;
        logic       key;
        logic [1:0] cur;
        logic [23:0] hex;
        logic [5:0] blank;
        logic [3:0] ack;
    } vec_t;
    vec_t tbl[$];

    hex_display_arbiter #(.NUM_SRC(4), .DWELL_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
        .src_ack(src_ack), .key_next_n(key_next_n), .hold(hold),
        .hex_digits(hex_digits), .digit_blank(digit_blank), .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [1:0] cur, input logic [23:0] hex,
                           input logic [5:0] blank, input logic [3:0] ack);
        chk({nm, " cur"},   32'(cur_src),     32'(cur));
        chk({nm, " hex"},   32'(hex_digits),  32'(hex));
        chk({nm, " blank"}, 32'(digit_blank), 32'(blank));
        chk({nm, " ack"},   32'(src_ack),     32'(ack));
    endtask

    initial begin
        src_data = {24'h333333, 24'hABCDEF, 24'h111111, 24'h123456};
        // reset, then idle with no data
        tbl.push_back('{2,  1, 4'b0000, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b0000});
        tbl.push_back('{20, 0, 4'b0000, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b0000});
        // sources 0 and 2, timer rotation
        tbl.push_back('{1,  1, 4'b0000, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b0000});
        tbl.push_back('{1,  0, 4'b0101, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b0101});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd0, 24'h123456, 6'h00, 4'b0000});
        tbl.push_back('{5,  0, 4'b0000, 0, 1, 2'd0, 24'h123456, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd2, 24'h123456, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd2, 24'hABCDEF, 6'h00, 4'b0000});
        tbl.push_back('{6,  0, 4'b0000, 0, 1, 2'd2, 24'hABCDEF, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd0, 24'hABCDEF, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd0, 24'h123456, 6'h00, 4'b0000});
        // hold freezes timer; key still advances once
        tbl.push_back('{30, 0, 4'b0000, 1, 1, 2'd0, 24'h123456, 6'h00, 4'b0000});
        tbl.push_back('{5,  0, 4'b0000, 1, 0, 2'd0, 24'h123456, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 1, 0, 2'd2, 24'h123456, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 1, 0, 2'd2, 24'hABCDEF, 6'h00, 4'b0000});
        tbl.push_back('{11, 0, 4'b0000, 1, 0, 2'd2, 24'hABCDEF, 6'h00, 4'b0000});
        tbl.push_back('{10, 0, 4'b0000, 1, 1, 2'd2, 24'hABCDEF, 6'h00, 4'b0000});
        // sources 1 and 3; press and expiry coincide at cur=1
        tbl.push_back('{1,  1, 4'b0000, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b0000});
        tbl.push_back('{1,  0, 4'b1010, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b1010});
        tbl.push_back('{6,  0, 4'b0000, 0, 1, 2'd0, 24'h000000, 6'h3F, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd1, 24'h000000, 6'h3F, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd1, 24'h111111, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 1, 2'd1, 24'h111111, 6'h00, 4'b0000});
        tbl.push_back('{5,  0, 4'b0000, 0, 0, 2'd1, 24'h111111, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 0, 2'd3, 24'h111111, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 0, 2'd3, 24'h333333, 6'h00, 4'b0000});
        tbl.push_back('{6,  0, 4'b0000, 0, 0, 2'd3, 24'h333333, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 0, 2'd1, 24'h333333, 6'h00, 4'b0000});
        tbl.push_back('{1,  0, 4'b0000, 0, 0, 2'd1, 24'h111111, 6'h00, 4'b0000});
        tbl.push_back('{10, 0, 4'b0000, 1, 1, 2'd1, 24'h111111, 6'h00, 4'b0000});

        foreach (tbl[i]) begin
            reset      = tbl[i].rst;
            src_valid  = tbl[i].v;
            hold       = tbl[i].hold;
            key_next_n = tbl[i].key;
            repeat (tbl[i].n) step();
            chk_all($sformatf("vec%0d", i), tbl[i].cur, tbl[i].hex, tbl[i].blank, tbl[i].ack);
        end

        // bounces shorter than the debounce window never advance
        hold = 1'b1;
        for (int p = 0; p < 5; p++) begin
            key_next_n = 1'b0;
            repeat (3) begin
                step();
                chk($sformatf("bounce%0d low cur", p), 32'(cur_src), 32'd1);
            end
            key_next_n = 1'b1;
            repeat (3) begin
                step();
                chk($sformatf("bounce%0d high cur", p), 32'(cur_src), 32'd1);
            end
        end
        repeat (6) step();
        chk("bounce settle cur", 32'(cur_src), 32'd1);

        // continuous writes to source 0 with a one-cycle reset mid-stream
        hold = 1'b0;
        reset = 1'b1;
        src_valid = 4'b0000;
        step();
        chk_all("stream rst", 2'd0, 24'h0, 6'h3F, 4'b0000);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            src_data[23:0] = 24'(c);
            src_valid = 4'b0001;
            step();
            chk_all($sformatf("stream%0d", c), 2'd0, (c == 1) ? 24'h0 : 24'(c - 1),
                    (c == 1) ? 6'h3F : 6'h00, 4'b0001);
        end
        reset = 1'b1;
        src_data[23:0] = 24'd7;
        step();
        chk_all("stream midrst", 2'd0, 24'h0, 6'h3F, 4'b0000);
        reset = 1'b0;
        src_data[23:0] = 24'd8;
        step();
        chk_all("stream re1", 2'd0, 24'h0, 6'h3F, 4'b0001);
        src_data[23:0] = 24'd9;
        step();
        chk_all("stream re2", 2'd0, 24'd8, 6'h00, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
